// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting one shared port to one of N_REQ requesters per transaction,
// with release on last/request-drop and an optional watchdog that revokes overlong grants.
module rr_resource_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ID_W           = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [ID_W-1:0]  timeout_id_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic             WD_EN    = (TIMEOUT_CYCLES > 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [N_REQ-1:0]   gnt_n;
  logic [ID_W-1:0]    gnt_id_n;
  logic               busy_n;
  logic               timeout_n;
  logic [ID_W-1:0]    timeout_id_n;

  logic               found;
  logic [ID_W-1:0]    win;
  logic [ID_W:0]      cand;
  logic               rel;
  logic               wd_fire;

  // Rotating search: first active request at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && req_i[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  // Only the owner's last/req bits matter; a release in the final cycle beats the watchdog.
  assign rel     = last_i[gnt_id_o] | ~req_i[gnt_id_o];
  assign wd_fire = WD_EN && (cnt == CNT_LAST) && !rel;

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    cnt_n        = cnt;
    gnt_n        = gnt_o;
    gnt_id_n     = gnt_id_o;
    busy_n       = busy_o;
    timeout_n    = 1'b0;
    timeout_id_n = timeout_id_o;
    case (state)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        if (found) begin
          state_n  = GRANT;
          gnt_n    = N_REQ'(1) << win;
          gnt_id_n = win;
          busy_n   = 1'b1;
          cnt_n    = '0;
          ptr_n    = (win == LAST_ID) ? '0 : win + 1'b1;
        end
      end
      GRANT: begin
        if (rel || wd_fire) begin
          state_n   = IDLE;
          gnt_n     = '0;
          busy_n    = 1'b0;
          timeout_n = wd_fire;
          if (wd_fire) timeout_id_n = gnt_id_o;
        end else if (WD_EN) begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      gnt_o        <= '0;
      gnt_id_o     <= '0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      gnt_o        <= gnt_n;
      gnt_id_o     <= gnt_id_n;
      busy_o       <= busy_n;
      timeout_o    <= timeout_n;
      timeout_id_o <= timeout_id_n;
    end
  end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Scoreboard bench for rr_resource_arbiter: the driver queues hand-computed outputs per cycle,
// the monitor pops them after each clock (or async reset) edge and compares.
module tb_rr_resource_arbiter;

  localparam int N_REQ          = 4;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int ID_W           = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] last = '0;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;
  logic [ID_W-1:0]  timeout_id;

  always #5 clk = ~clk;

  rr_resource_arbiter #(
    .N_REQ(N_REQ),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .last_i(last),
    .gnt_o(gnt),
    .gnt_id_o(gnt_id),
    .busy_o(busy),
    .timeout_o(timeout),
    .timeout_id_o(timeout_id)
  );

  typedef struct {
    string           name;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  id;
    logic             busy;
    logic             tmo;
    logic [ID_W-1:0]  tid;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 1'b0;
  bit   rst_seen = 1'b0;

  // Applies one cycle of inputs at the falling edge and queues the outputs expected after the next rise.
  task automatic step(input string name, input logic r, input logic [N_REQ-1:0] rq,
                      input logic [N_REQ-1:0] ls, input logic [N_REQ-1:0] eg,
                      input logic [ID_W-1:0] eid, input logic eb, input logic et,
                      input logic [ID_W-1:0] etid);
    exp_t e;
    @(negedge clk);
    if (r && !rst) begin
      e.name = "reset_async"; e.gnt = '0; e.id = '0; e.busy = 1'b0; e.tmo = 1'b0; e.tid = '0;
      q.push_back(e);
    end
    e.name = name; e.gnt = eg; e.id = eid; e.busy = eb; e.tmo = et; e.tid = etid;
    q.push_back(e);
    rst  = r;
    req  = rq;
    last = ls;
  endtask

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N_REQ-1:0] oh;
    step("reset",    1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step("reset",    1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step("idle",     0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step("idle",     0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);

    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << order[j];
      step("rr_grant",   0, 4'b1111, 4'b0000, oh, ID_W'(order[j]), 1, 0, 0);
      step("rr_hold",    0, 4'b1111, 4'b0000, oh, ID_W'(order[j]), 1, 0, 0);
      step("rr_hold",    0, 4'b1111, 4'b0000, oh, ID_W'(order[j]), 1, 0, 0);
      step("rr_release", 0, 4'b1111, oh, 4'b0000, ID_W'(order[j]), 0, 0, 0);
    end
    step("rr_idle",      0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);

    step("single_grant", 0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0, 0);
    repeat (4) step("single_hold", 0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0, 0);
    step("single_last",  0, 4'b0100, 4'b0100, 4'b0000, 2, 0, 0, 0);
    step("single_idle",  0, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0, 0);

    step("drop_grant",   0, 4'b1001, 4'b0000, 4'b1000, 3, 1, 0, 0);
    repeat (3) step("drop_hold", 0, 4'b1001, 4'b0000, 4'b1000, 3, 1, 0, 0);
    step("drop_release", 0, 4'b0001, 4'b0000, 4'b0000, 3, 0, 0, 0);
    step("drop_next",    0, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, 0);
    step("drop_end",     0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0);
    step("drop_idle",    0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);

    step("wd_grant",     0, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, 0);
    repeat (2) step("nonowner_last", 0, 4'b0001, 4'b0100, 4'b0001, 0, 1, 0, 0);
    repeat (5) step("wd_hold", 0, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, 0);
    step("release_at_timeout", 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0);
    step("wd_idle",      0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);

    step("to_grant",     0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0, 0);
    repeat (7) step("to_hold", 0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0, 0);
    step("to_fire",      0, 4'b0010, 4'b0000, 4'b0000, 1, 0, 1, 1);
    step("to_after",     0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 1);

    step("rst_grant",    0, 4'b1010, 4'b0000, 4'b1000, 3, 1, 0, 1);
    step("rst_hold",     0, 4'b1010, 4'b0000, 4'b1000, 3, 1, 0, 1);
    step("rst_mid",      1, 4'b1010, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step("rst_regrant",  0, 4'b1010, 4'b0000, 4'b0010, 1, 1, 0, 0);
    step("rst_last",     0, 4'b1010, 4'b0010, 4'b0000, 1, 0, 0, 0);
    step("rst_idle",     0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    done = 1'b1;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #2;
      cyc++;
      if (rst) rst_seen = 1'b1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({gnt, gnt_id, busy, timeout, timeout_id} !== {e.gnt, e.id, e.busy, e.tmo, e.tid}) begin
          errors++;
          $display("FAIL %s: got gnt=%b id=%0d busy=%b tmo=%b tid=%0d, expected gnt=%b id=%0d busy=%b tmo=%b tid=%0d",
                   e.name, gnt, gnt_id, busy, timeout, timeout_id, e.gnt, e.id, e.busy, e.tmo, e.tid);
        end
      end
      if (rst_seen && !rst) begin
        checks++;
        if (busy !== (|gnt) || !$onehot0(gnt)) begin
          errors++;
          $display("FAIL invariant: got gnt=%b busy=%b, expected one-hot/zero gnt with busy=|gnt", gnt, busy);
        end
      end
      if (done && q.size() == 0) break;
      if (cyc > 2000) begin
        errors++;
        $display("FAIL cycle_budget: got %0d responses still pending, expected 0", q.size());
        break;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
